// File: rtl/bcd_conv_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per cycle, MSB first).
// Optional macro BCD_CONV_SIGN_EN: two's-complement input, magnitude conversion, out_neg flag.

module bcd_digit_adj (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module bcd_conv_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] out_bcd,
  output logic                out_ovf,
`ifdef BCD_CONV_SIGN_EN
  output logic                out_neg,
`endif
  output logic                busy
);
  localparam int BW = 4*DIGITS;
  localparam int CW = $clog2(WIDTH+1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] mag;
  logic [BW-1:0]    acc, adj;
  logic [CW-1:0]    cnt;
  logic             ovf_acc;
  logic             steps_done;

`ifdef BCD_CONV_SIGN_EN
  logic neg;
  // -2^(WIDTH-1) negates to itself, which read unsigned is the right magnitude
  assign mag = in_data[WIDTH-1] ? -in_data : in_data;
`else
  assign mag = in_data;
`endif

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_dig
      bcd_digit_adj u_adj (.d(acc[4*g +: 4]), .q(adj[4*g +: 4]));
    end
  endgenerate

  assign steps_done = (cnt == CW'(WIDTH));
  assign in_ready   = (state == IDLE) && !rst;
  assign out_valid  = (state == DONE);
  assign busy       = (state == SHIFT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)   state_nxt = SHIFT;
      SHIFT:   if (steps_done) state_nxt = DONE;
      DONE:    if (out_ready)  state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh      <= '0;
      acc     <= '0;
      cnt     <= '0;
      ovf_acc <= 1'b0;
      out_bcd <= '0;
      out_ovf <= 1'b0;
`ifdef BCD_CONV_SIGN_EN
      neg     <= 1'b0;
      out_neg <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sh      <= mag;
          acc     <= '0;
          cnt     <= '0;
          ovf_acc <= 1'b0;
`ifdef BCD_CONV_SIGN_EN
          neg     <= in_data[WIDTH-1];
`endif
        end
        SHIFT: if (!steps_done) begin
          // the bit leaving the top digit is value lost past DIGITS digits
          ovf_acc <= ovf_acc | adj[BW-1];
          acc     <= {adj[BW-2:0], sh[WIDTH-1]};
          sh      <= {sh[WIDTH-2:0], 1'b0};
          cnt     <= cnt + 1'b1;
        end else begin
          out_bcd <= ovf_acc ? {DIGITS{4'h9}} : acc;
          out_ovf <= ovf_acc;
`ifdef BCD_CONV_SIGN_EN
          out_neg <= neg;
`endif
        end
        default: ;
      endcase
    end
  end
endmodule
